// File: rtl/bitrev_reorder_ctrl_if.sv
// ---------------------------------------------------------------------------
// bitrev_reorder_ctrl_if
//   Streaming bus for the bit-reversal reorder stage. It carries both the
//   natural-order input stream and the bit-reversed output stream.
//
//   Signals
//     in_valid   upstream has a sample on in_data
//     in_ready   reorder stage can accept a sample
//     in_data    input sample, natural order (DATA_W bits)
//     out_valid  out_data holds a valid sample
//     out_ready  downstream accepts the output sample
//     out_data   output sample, bit-reversed order (DATA_W bits)
//     out_first  out_data is index 0 of a frame
//     out_last   out_data is the final sample of a frame
//
//   Modports
//     master  the surrounding datapath (source of input, sink of output)
//     slave   the reorder controller itself
// ---------------------------------------------------------------------------
interface bitrev_reorder_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_first;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/bitrev_reorder_ctrl.sv
// ---------------------------------------------------------------------------
// bitrev_reorder_ctrl
//   Streaming reorder stage for the FFT/IFFT path. Natural-order samples are
//   written into one of two N-entry banks. Each group of N accepted samples
//   is one frame. When a bank is full, it is read back in bit-reversed index
//   order through a registered valid/ready output. One bank can fill while
//   the other drains, so the stage sustains one sample per cycle.
//
//   Parameters
//     N       frame length in samples (power of two, >= 2)
//     DATA_W  width of one packed complex sample
//
//   Ports
//     clk     clock, all logic on the rising edge
//     reset   synchronous, active-high reset
//     bus     bitrev_reorder_ctrl_if.slave (input and output handshakes)
//     busy    a bank is full, or a write/read count is nonzero
//     bypass  (only with BITREV_BYPASS_EN) read the next frame in natural
//             order; sampled when index 0 of a frame is loaded
//
//   Build option
//     BITREV_BYPASS_EN  adds the bypass input. If it is left undefined,
//                       every frame is bit-reversed.
// ---------------------------------------------------------------------------
module bitrev_reorder_ctrl #(
  parameter int N      = 8,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  bitrev_reorder_ctrl_if.slave   bus,
`ifdef BITREV_BYPASS_EN
  input  logic                   bypass,
`endif
  output logic                   busy
);

  localparam int CNT_W = $clog2(N);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic { IDLE, STREAM } state_t;

  localparam cnt_t LAST_IDX = cnt_t'(N - 1);

  // Both banks sit in one array. The bank select is the top address bit.
  logic [DATA_W-1:0] mem [2*N];

  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_bank;
  logic       rd_bank;
  cnt_t       wr_cnt;
  cnt_t       rd_cnt;
  logic       ready_en;
  state_t     state;

  logic       wr_fire;
  logic       wr_done;
  logic       out_free;
  logic       rd_load;
  logic       rd_done;
  logic       rd_natural;
  cnt_t       rd_addr;

  function automatic cnt_t bitrev(input cnt_t k);
    cnt_t r;
    for (int j = 0; j < CNT_W; j++) begin
      r[j] = k[CNT_W-1-j];
    end
    return r;
  endfunction

  // ready_en holds in_ready low for the reset cycle. Otherwise in_ready
  // depends only on whether the write bank is still occupied.
  assign bus.in_ready = ready_en & ~full[wr_bank];
  assign wr_fire      = bus.in_valid & bus.in_ready;
  assign wr_done      = wr_fire && (wr_cnt == LAST_IDX);

  // The output register can take a new sample when it is empty or is being
  // drained on this edge.
  assign out_free = !bus.out_valid || bus.out_ready;

  // In STREAM the read bank is always full: STREAM is only entered or kept
  // when full[rd_bank] is set. IDLE loads directly, so index 0 appears one
  // edge after the frame completes.
  assign rd_load = out_free && ((state == STREAM) || full[rd_bank]);
  assign rd_done = rd_load && (rd_cnt == LAST_IDX);

`ifdef BITREV_BYPASS_EN
  logic bypass_q;
  // Index 0 uses the live bypass input. The rest of the frame uses the
  // value captured with index 0.
  assign rd_natural = (rd_cnt == '0) ? bypass : bypass_q;
`else
  assign rd_natural = 1'b0;
`endif

  assign rd_addr = rd_natural ? rd_cnt : bitrev(rd_cnt);

  // Filling one bank and freeing the other can happen on the same edge.
  // Both updates are merged here.
  always_comb begin
    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  // NOTE: sample storage has no reset; stale contents are never read because the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank, wr_cnt}] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (reset) begin
      state         <= IDLE;
      full          <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      ready_en      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
`ifdef BITREV_BYPASS_EN
      bypass_q      <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;
      full     <= full_nxt;

      // Write side: fill the current bank, then switch to the other bank.
      if (wr_fire) begin
        if (wr_done) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt  <= wr_cnt + cnt_t'(1);
        end
      end

      // Output register: load the next reordered sample, drop valid once
      // the last sample is taken, or hold while stalled.
      if (rd_load) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= mem[{rd_bank, rd_addr}];
        bus.out_first <= (rd_cnt == '0);
        bus.out_last  <= (rd_cnt == LAST_IDX);
`ifdef BITREV_BYPASS_EN
        if (rd_cnt == '0) bypass_q <= bypass;
`endif
        if (rd_done) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt  <= rd_cnt + cnt_t'(1);
        end
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      // Read sequencer.
      case (state)
        IDLE: begin
          if (rd_load) state <= STREAM;
        end
        STREAM: begin
          if (rd_done) state <= full_nxt[~rd_bank] ? STREAM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (|full) || (|wr_cnt) || (|rd_cnt);

endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bitrev_reorder_ctrl
//   Self-checking bench for bitrev_reorder_ctrl (N=8, DATA_W=32).
//
//   The reference model is kept at the frame level. Each accepted input is
//   queued in arrival order. A group of N forms a frame. Each output sample
//   is expected to be frame[rev(k)], where rev() is computed by repeated
//   halving. A bypassed frame uses frame[k] instead. The expected first and
//   last flags follow from k.
// ---------------------------------------------------------------------------
module tb_bitrev_reorder_ctrl;
  localparam int N      = 8;
  localparam int DATA_W = 32;
  localparam int LOGN   = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef BITREV_BYPASS_EN
  logic bypass;
`endif

  bitrev_reorder_ctrl_if #(.DATA_W(DATA_W)) bus ();

  bitrev_reorder_ctrl #(.N(N), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
`ifdef BITREV_BYPASS_EN
    .bypass (bypass),
`endif
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int          cyc = 0;
  logic [31:0] part    [$];
  logic [31:0] frame_q [$];
  logic [31:0] cur     [N];
  int          pos       = 0;
  bit          cur_byp   = 1'b0;
  bit          model_bypass = 1'b0;
  int          out_count = 0;
  int          stall_cnt = 0;
  int          gaps      = 0;
  bit          track_gap = 1'b0;
  bit          have_last = 1'b0;
  int          last_cyc  = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_first;
  logic        prev_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev_idx(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < LOGN; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: it samples at negedge what the next rising edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      part.delete();
      frame_q.delete();
      pos        = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_data",  bus.out_data,  prev_data);
        check("stall_first", bus.out_first, prev_first);
        check("stall_last",  bus.out_last,  prev_last);
      end
      if (bus.in_valid && bus.in_ready) begin
        part.push_back(bus.in_data);
        if (part.size() == N) begin
          foreach (part[i]) frame_q.push_back(part[i]);
          part.delete();
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (pos == 0) begin
          check("out_frame_avail", frame_q.size() >= N, 1'b1);
          for (int i = 0; i < N; i++) cur[i] = (frame_q.size() > 0) ? frame_q.pop_front() : 'x;
          cur_byp = model_bypass;
        end
        check("out_data",  bus.out_data,  cur[cur_byp ? pos : rev_idx(pos)]);
        check("out_first", bus.out_first, pos == 0);
        check("out_last",  bus.out_last,  pos == N - 1);
        if (track_gap && have_last && (cyc != last_cyc + 1)) gaps++;
        have_last = 1'b1;
        last_cyc  = cyc;
        pos       = (pos + 1) % N;
        out_count++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_first = bus.out_first;
      prev_last  = bus.out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and return #1 after the edge that accepts it.
  task automatic send(input logic [31:0] d);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int w = 0; w < 300 && !ok; w++) begin
      @(negedge clk);
      ok = bus.in_ready;
      if (!ok) stall_cnt++;
      step();
    end
    if (!ok) check("send_timeout", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = (frame_q.size() == 0) && (pos == 0) && !bus.out_valid;
      step();
    end
    check("drain_done", done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
`ifdef BITREV_BYPASS_EN
    bypass        = 1'b0;
`endif
    repeat (2) step();
    check("rst_in_ready",  bus.in_ready,  1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data,  32'h0);
    check("rst_out_first", bus.out_first, 1'b0);
    check("rst_out_last",  bus.out_last,  1'b0);
    check("rst_busy",      busy,          1'b0);
    reset = 1'b0;
    step();
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // 1: one frame, latency of one edge after the last accept.
    base = out_count;
    for (int i = 0; i < N; i++) send(i);
    check("t1_lat_pre",   bus.out_valid, 1'b0);
    step();
    check("t1_lat_valid", bus.out_valid, 1'b1);
    check("t1_lat_data",  bus.out_data,  32'd0);
    check("t1_lat_first", bus.out_first, 1'b1);
    drain();
    check("t1_count", out_count - base, N);

    // 2: three frames back to back; no input stall, no output bubble.
    base = out_count; stall_cnt = 0; gaps = 0; have_last = 1'b0; track_gap = 1'b1;
    for (int i = 0; i < 3 * N; i++) send(i);
    check("t2_in_stall", stall_cnt, 0);
    drain();
    track_gap = 1'b0;
    check("t2_gaps",  gaps, 0);
    check("t2_count", out_count - base, 3 * N);

    // 3: output blocked; two frames buffer, the third stalls.
    base = out_count;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) send(i);
    bus.in_valid = 1'b1;
    bus.in_data  = 2 * N;
    repeat (6) begin
      @(negedge clk);
      check("t3_in_ready",  bus.in_ready,  1'b0);
      check("t3_out_valid", bus.out_valid, 1'b1);
      check("t3_out_data",  bus.out_data,  32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 2 * N; i < 3 * N; i++) send(i);
    drain();
    check("t3_count", out_count - base, 3 * N);

    // 4: out_ready toggles every cycle.
    base = out_count;
    fork
      for (int i = 0; i < 2 * N; i++) send(300 + i);
      begin
        repeat (60) begin
          bus.out_ready = ~bus.out_ready;
          step();
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("t4_count", out_count - base, 2 * N);

    // Random data, random input gaps, random backpressure.
    base = out_count;
    fork
      for (int i = 0; i < 4 * N; i++) begin
        repeat ($urandom_range(0, 2)) step();
        send($urandom);
      end
      begin
        repeat (150) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          step();
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("rand_count", out_count - base, 4 * N);

    // 5: reset in the middle of a frame discards the partial frame.
    for (int i = 0; i < 5; i++) send(500 + i);
    check("t5_busy_pre", busy, 1'b1);
    reset = 1'b1;
    step();
    check("t5_busy",      busy,          1'b0);
    check("t5_out_valid", bus.out_valid, 1'b0);
    check("t5_in_ready",  bus.in_ready,  1'b0);
    reset = 1'b0;
    step();
    base = out_count;
    for (int i = 0; i < N; i++) send(100 + i);
    drain();
    check("t5_count", out_count - base, N);
    check("t5_busy_end", busy, 1'b0);

`ifdef BITREV_BYPASS_EN
    // 6: natural-order frame followed by a bit-reversed frame.
    base = out_count;
    model_bypass = 1'b1;
    bypass       = 1'b1;
    for (int i = 0; i < N; i++) send(i);
    drain();
    model_bypass = 1'b0;
    bypass       = 1'b0;
    for (int i = 0; i < N; i++) send(i);
    drain();
    check("t6_count", out_count - base, 2 * N);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
